// File: rtl/common_pkg.sv
// Shared pipeline types: the instruction word, the IF/ID payload, the fetch FSM states.
package common;

  typedef logic [31:0] instruction_type;

  typedef struct packed {
    logic [31:0]     pc;
    instruction_type instruction;
  } if_id_type;

  typedef enum logic {
    FETCH_BOOT,
    FETCH_RUN
  } fetch_state_type;

  // addi x0, x0, 0
  localparam instruction_type NOP_INSTRUCTION = 32'h0000_0013;

endpackage

// File: rtl/fetch_prefetch_unit_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; head is read combinationally.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves at the same edge.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage write.
  // NOTE: the data array has no reset; pointers and count define validity, so
  // leaving it unreset keeps it a plain RAM without a reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one edge.
  // NOTE: sequential state is written only with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch: credit-limited pipelined requests, in-order response pairing,
// prefetch buffer towards decode, and flush with discard of wrong-path responses.
module fetch_prefetch_unit
  import common::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_target,
  output logic        if_id_valid,
  output if_id_type   if_id_out
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int OCW = $clog2(MAX_OUTSTANDING) + 1;

  fetch_state_type state;
  fetch_state_type next_state;
  logic [31:0]     fetch_pc;
  logic [OCW-1:0]  discard;

  logic            grant;
  logic            drop;
  logic            credit_ok;
  logic [31:0]     in_use;
  logic [OCW-1:0]  outstanding_next;

  logic            buf_push;
  logic            buf_pop;
  logic            buf_full;
  logic            buf_empty;
  logic [FCW-1:0]  buf_count;
  if_id_type       buf_head;

  logic            pcq_full;
  logic            pcq_empty;
  logic [OCW-1:0]  pcq_count;
  logic [31:0]     pcq_head;

  // Every accepted request occupies a buffer slot until decode takes it, so the
  // buffer can never overflow.
  assign in_use    = 32'(buf_count) + 32'(pcq_count);
  assign credit_ok = !buf_full && !pcq_full && (in_use < 32'(FIFO_DEPTH));

  assign grant            = imem_req && imem_gnt;
  assign drop             = flush || (discard != '0);
  assign buf_push         = imem_rvalid && !drop;
  assign buf_pop          = !buf_empty && !stall && !flush;
  assign outstanding_next = pcq_count + OCW'(grant) - OCW'(imem_rvalid);
  assign imem_addr        = fetch_pc;
  assign if_id_valid      = !buf_empty;

  // Prefetch buffer of {pc, instruction} towards decode.
  sync_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (buf_push),
    .pop     (buf_pop),
    .flush   (flush),
    .wdata   ({pcq_head, imem_rdata}),
    .rdata   (buf_head),
    .full    (buf_full),
    .empty   (buf_empty),
    .count   (buf_count)
  );

  // PCs of in-flight requests; survives flush so late responses still pair up.
  sync_fifo #(.WIDTH(32), .DEPTH(MAX_OUTSTANDING)) u_pcq (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (grant),
    .pop     (imem_rvalid && !pcq_empty),
    .flush   (1'b0),
    .wdata   (fetch_pc),
    .rdata   (pcq_head),
    .full    (pcq_full),
    .empty   (pcq_empty),
    .count   (pcq_count)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FETCH_BOOT;
    else          state <= next_state;
  end

  // Next state and request valid.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    imem_req   = 1'b0;
    case (state)
      FETCH_BOOT: next_state = FETCH_RUN;
      FETCH_RUN:  imem_req   = credit_ok && !flush;
      default:    next_state = FETCH_BOOT;
    endcase
  end

  // Fetch address: redirect wins, otherwise advance on grant (wraps at 2^32).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   fetch_pc <= RESET_PC;
    else if (flush) fetch_pc <= flush_target & ~32'h3;
    else if (grant) fetch_pc <= fetch_pc + 32'd4;
  end

  // Wrong-path responses still owed after a flush are dropped in arrival order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           discard <= '0;
    else if (flush)                         discard <= outstanding_next;
    else if (imem_rvalid && discard != '0)  discard <= discard - 1'b1;
  end

  // Decode view: buffer head, or a NOP at pc 0 when nothing is buffered.
  always_comb begin
    if_id_out = buf_head;
    if (buf_empty) begin
      if_id_out.pc          = 32'h0;
      if_id_out.instruction = NOP_INSTRUCTION;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: in-order memory model with random grant/latency,
// a stream model of the PCs decode must see, and directed scenario steps.
module tb_fetch_prefetch_unit;
  import common::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic [31:0] flush_target;
  logic        if_id_valid;
  if_id_type   if_id_out;

  fetch_prefetch_unit #(
    .RESET_PC        (RST_PC),
    .FIFO_DEPTH      (4),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .flush        (flush),
    .flush_target (flush_target),
    .if_id_valid  (if_id_valid),
    .if_id_out    (if_id_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  mem_req_t    mem_q[$];
  int          edge_no    = 0;
  int          gnt_pct    = 100;
  int          gnt_budget = -1;
  int          lat_min    = 1;
  int          lat_max    = 1;
  logic [31:0] exp_pc     = RST_PC;
  int          consumed   = 0;
  int          checks     = 0;
  int          failures   = 0;
  if_id_type   held;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory drives its pins at the falling edge, then at +4 the upcoming rising
  // edge is modelled: grants queue, responses retire, decode consumption is checked.
  always @(negedge clk) begin
    if (mem_q.size() != 0 && mem_q[0].due <= edge_no) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    imem_gnt = (gnt_budget != 0) && (int'($urandom_range(99)) < gnt_pct);
    #4;
    if (!reset_n) begin
      mem_q.delete();
      exp_pc = RST_PC;
    end else begin
      check("fifo_overflow", 64'(dut.buf_full && dut.buf_push && !dut.buf_pop), 64'h0);
      if (imem_req) check("addr_align", 64'(imem_addr[1:0]), 64'h0);
      if (flush) check("req_during_flush", 64'(imem_req), 64'h0);
      if (!if_id_valid) check("empty_is_nop", if_id_out, {32'h0, NOP_INSTRUCTION});
      if (imem_rvalid) void'(mem_q.pop_front());
      if (imem_req && imem_gnt) begin
        mem_q.push_back('{imem_addr, edge_no + int'($urandom_range(lat_max, lat_min))});
        if (gnt_budget > 0) gnt_budget--;
      end
      if (if_id_valid && !stall && !flush) begin
        check("stream_pc", 64'(if_id_out.pc), 64'(exp_pc));
        check("stream_instr", 64'(if_id_out.instruction), 64'(mem_word(exp_pc)));
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      if (flush) exp_pc = flush_target & ~32'h3;
    end
    edge_no++;
  end

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #3;
      if (if_id_valid) return;
    end
    check({tag, "_timeout"}, 64'h0, 64'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit hit;
    reset_n      = 1'b0;
    stall        = 1'b0;
    flush        = 1'b0;
    flush_target = 32'h0;

    // Reset values.
    repeat (3) @(negedge clk);
    #3;
    check("rst_req", 64'(imem_req), 64'h0);
    check("rst_addr", 64'(imem_addr), 64'(RST_PC));
    check("rst_valid", 64'(if_id_valid), 64'h0);
    check("rst_out", if_id_out, {32'h0, NOP_INSTRUCTION});

    // Boot cycle, then streaming from RESET_PC with a 1-cycle memory.
    @(negedge clk); reset_n = 1'b1; #3;
    check("boot_no_req", 64'(imem_req), 64'h0);
    @(negedge clk); #3;
    check("first_req", 64'(imem_req), 64'h1);
    check("first_addr", 64'(imem_addr), 64'h100);
    @(negedge clk); #3;
    check("second_addr", 64'(imem_addr), 64'h104);
    check("not_yet_valid", 64'(if_id_valid), 64'h0);
    @(negedge clk); #3;
    check("first_valid", 64'(if_id_valid), 64'h1);
    check("first_pc", 64'(if_id_out.pc), 64'h100);
    check("first_instr", 64'(if_id_out.instruction), 64'(mem_word(32'h100)));
    @(negedge clk); #3;
    check("second_pc", 64'(if_id_out.pc), 64'h104);

    // Stall for 10 cycles: buffer fills, requests stop, output holds.
    @(negedge clk); stall = 1'b1; #3;
    held = if_id_out;
    check("stall_valid", 64'(if_id_valid), 64'h1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #3;
      check("stall_hold", if_id_out, held);
    end
    check("stall_req_off", 64'(imem_req), 64'h0);
    check("stall_full", 64'(dut.buf_count), 64'h4);
    @(negedge clk); stall = 1'b0;
    repeat (6) @(negedge clk);

    // Flush with exactly three requests outstanding.
    #3; gnt_budget = 0;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk); #3;
      hit = (mem_q.size() == 0);
    end
    check("drain_done", 64'(hit), 64'h1);
    lat_min = 6; lat_max = 6; gnt_budget = 3;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk); #3;
      hit = (mem_q.size() == 3) && (gnt_budget == 0);
    end
    check("three_outstanding", 64'(mem_q.size()), 64'h3);
    lat_min = 1; lat_max = 1; gnt_budget = -1;
    @(negedge clk); flush = 1'b1; flush_target = 32'h2002; #3;
    check("flush_req_low", 64'(imem_req), 64'h0);
    @(negedge clk); flush = 1'b0;
    wait_valid("redirect_first");
    check("redirect_pc0", 64'(if_id_out.pc), 64'h2000);
    check("redirect_instr0", 64'(if_id_out.instruction), 64'(mem_word(32'h2000)));
    wait_valid("redirect_second");
    check("redirect_pc1", 64'(if_id_out.pc), 64'h2004);

    // Flush coinciding with a response while stalled.
    @(negedge clk); stall = 1'b1;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk); #2;
      if (imem_rvalid) begin
        flush = 1'b1; flush_target = 32'h3000; hit = 1;
      end
    end
    check("rvalid_for_flush", 64'(hit), 64'h1);
    #1;
    check("flush_rv_req_low", 64'(imem_req), 64'h0);
    @(negedge clk); flush = 1'b0; #3;
    check("flush_rv_empty", 64'(if_id_valid), 64'h0);
    wait_valid("flush_rv_target");
    check("flush_rv_pc", 64'(if_id_out.pc), 64'h3000);
    @(negedge clk); stall = 1'b0;

    // Address wrap at the top of the address space.
    @(negedge clk); flush = 1'b1; flush_target = 32'hFFFF_FFF8;
    @(negedge clk); flush = 1'b0;
    wait_valid("wrap0");
    check("wrap_pc0", 64'(if_id_out.pc), 64'hFFFF_FFF8);
    wait_valid("wrap1");
    check("wrap_pc1", 64'(if_id_out.pc), 64'hFFFF_FFFC);
    wait_valid("wrap2");
    check("wrap_pc2", 64'(if_id_out.pc), 64'h0);

    // Randomized traffic: grant gaps, variable latency, stalls and redirects.
    gnt_pct = 70; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      stall        = ($urandom_range(3) == 0);
      flush        = ($urandom_range(19) == 0);
      flush_target = $urandom;
    end
    @(negedge clk); stall = 1'b0; flush = 1'b0;
    check("random_progress", 64'(consumed > 150), 64'h1);

    // Asynchronous reset mid-burst, then restart from RESET_PC.
    repeat (3) @(negedge clk);
    #2; reset_n = 1'b0; #1;
    check("arst_valid", 64'(if_id_valid), 64'h0);
    check("arst_req", 64'(imem_req), 64'h0);
    check("arst_addr", 64'(imem_addr), 64'(RST_PC));
    @(negedge clk);
    @(negedge clk); reset_n = 1'b1; #3;
    check("reboot_no_req", 64'(imem_req), 64'h0);
    @(negedge clk); #3;
    check("reboot_req", 64'(imem_req), 64'h1);
    check("reboot_addr", 64'(imem_addr), 64'(RST_PC));
    wait_valid("reboot_first");
    check("reboot_pc", 64'(if_id_out.pc), 64'(RST_PC));

    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
